memory_access: RTL and testbench

Memory stage of the bf8b core. It sits between execute and `writeback`, and serialises 8-, 16- and 32-bit loads and stores onto the 8-bit external memory bus, one byte per acknowledged cycle, little-endian. It assembles load data zero-filled in `val`, because sign extension belongs to `writeback`. Non-memory ops pass their ALU result straight through.

---
 rtl/bf8b_pkg.sv | 34 +++
 rtl/memory_access_if.sv | 30 +++
 rtl/memory_access.sv | 119 +++++++++++
 tb/tb_memory_access.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bf8b_pkg.sv
// Shared definitions for the bf8b core: data widths, opcodes, memory access
// sizes and the memory-stage state encoding.
package bf8b_pkg;

    localparam int XLEN       = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int BUS_WIDTH  = 8;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] MEM_ACC_8  = 2'b00;
    localparam logic [1:0] MEM_ACC_16 = 2'b01;
    localparam logic [1:0] MEM_ACC_32 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

    // Index of the final byte of an access; the reserved 2'b11 size is a word.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] acc);
        logic [1:0] idx;
        case (acc)
            MEM_ACC_8:  idx = 2'd0;
            MEM_ACC_16: idx = 2'd1;
            MEM_ACC_32: idx = 2'd3;
            default:    idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Byte-wide external memory bus between the memory stage (master) and the
// memory system (slave).
interface memory_access_if;

    logic                           mem_req;
    logic                           mem_we;
    logic [bf8b_pkg::ADDR_WIDTH-1:0] mem_addr;
    logic [bf8b_pkg::BUS_WIDTH-1:0]  mem_wdata;
    logic [bf8b_pkg::BUS_WIDTH-1:0]  mem_rdata;
    logic                           mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/memory_access.sv
// Memory stage of the bf8b core: serialises 8/16/32-bit little-endian loads and
// stores onto the byte-wide bus; non-memory ops pass the ALU result through.
module memory_access
    import bf8b_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [XLEN-1:0]       store_data,
    input  logic [XLEN-1:0]       alu_result,
    memory_access_if.master       mem,
    output logic [XLEN-1:0]       val,
    output logic                  ready,
    output logic                  busy
);

    mem_state_t            state_reg;
    logic                  is_load_reg;
    logic [1:0]            last_idx_reg;
    logic [1:0]            idx_reg;
    logic [XLEN-1:0]       store_reg;
    logic [XLEN-1:0]       val_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [BUS_WIDTH-1:0]  wdata_reg;
    logic                  mem_req_reg;
    logic                  mem_we_reg;
    logic                  ready_reg;
    logic                  busy_reg;

    logic [1:0]            idx_next;
    logic                  is_mem_op;
    logic                  unused_funct3;

    assign idx_next      = idx_reg + 2'd1;
    assign is_mem_op     = (op == OP_LOAD) || (op == OP_STORE);
    // Signedness bit of funct3 is consumed by writeback, not here.
    assign unused_funct3 = funct3[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            is_load_reg  <= 1'b0;
            last_idx_reg <= 2'd0;
            idx_reg      <= 2'd0;
            store_reg    <= '0;
            val_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            mem_req_reg  <= 1'b0;
            mem_we_reg   <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (en) begin
                        busy_reg <= 1'b1;
                        if (is_mem_op) begin
                            state_reg    <= ST_ACCESS;
                            is_load_reg  <= (op == OP_LOAD);
                            last_idx_reg <= last_byte_idx(funct3[1:0]);
                            idx_reg      <= 2'd0;
                            store_reg    <= store_data;
                            val_reg      <= '0;
                            addr_reg     <= addr;
                            wdata_reg    <= store_data[BUS_WIDTH-1:0];
                            mem_req_reg  <= 1'b1;
                            mem_we_reg   <= (op == OP_STORE);
                        end else begin
                            state_reg <= ST_DONE;
                            val_reg   <= alu_result;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Without an ack every register simply holds (wait state).
                    if (mem.mem_ack) begin
                        if (is_load_reg) begin
                            val_reg[{idx_reg, 3'b000} +: BUS_WIDTH] <= mem.mem_rdata;
                        end
                        idx_reg   <= idx_next;
                        addr_reg  <= addr_reg + 1'b1;
                        wdata_reg <= store_reg[{idx_next, 3'b000} +: BUS_WIDTH];
                        if (idx_reg == last_idx_reg) begin
                            state_reg   <= ST_DONE;
                            mem_req_reg <= 1'b0;
                            mem_we_reg  <= 1'b0;
                            ready_reg   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    mem_req_reg <= 1'b0;
                    mem_we_reg  <= 1'b0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign val           = val_reg;
    assign ready         = ready_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the bf8b memory stage: a cycle-counting byte-bus responder
// with configurable wait states and hand-computed expectations.
module tb_memory_access;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0010011;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] alu_result;
    logic [31:0] val;
    logic        ready;
    logic        busy;

    memory_access_if bus ();

    memory_access dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .op         (op),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .alu_result (alu_result),
        .mem        (bus.master),
        .val        (val),
        .ready      (ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rbytes [4];
    logic [31:0] log_addr [8];
    logic [7:0]  log_wdata [8];
    logic        log_we [8];
    int          n_bytes;
    int          req_cycles;
    int          rdy_cycle;
    logic        req_at_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one op and plays the memory: ack every request after `waits` idle
    // cycles. Cycle 1 is the cycle after the accept edge.
    task automatic run_op(input string name, input logic [6:0] o, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] alu,
                          input int waits, input int en_pulse_at);
        int wcnt;
        n_bytes = 0; req_cycles = 0; rdy_cycle = -1; req_at_ready = 1'b0; wcnt = 0;
        @(negedge clk);
        en = 1'b1; op = o; funct3 = f3; addr = a; store_data = sd; alu_result = alu;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0; op = OP_ALU;
        for (int c = 1; c <= 40; c++) begin
            bus.mem_ack = 1'b0;
            if (c == en_pulse_at) begin
                en = 1'b1; op = OP_ALU; alu_result = 32'h0000_0BAD;
            end else begin
                en = 1'b0;
            end
            if (ready) begin
                rdy_cycle = c;
                req_at_ready = bus.mem_req;
                break;
            end
            if (bus.mem_req) begin
                req_cycles++;
                if (wcnt == waits) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rbytes[n_bytes % 4];
                    if (n_bytes < 8) begin
                        log_addr[n_bytes]  = bus.mem_addr;
                        log_wdata[n_bytes] = bus.mem_wdata;
                        log_we[n_bytes]    = bus.mem_we;
                    end
                    n_bytes++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
        end
        en = 1'b0; bus.mem_ack = 1'b0;
        if (rdy_cycle < 0) check({name, "_timeout"}, 32'd0, 32'd1);
        $display("txn %s addr=0x%08h bytes=%0d ready_cycle=%0d val=0x%08h",
                 name, a, n_bytes, rdy_cycle, val);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; op = OP_ALU; funct3 = 3'b000; addr = '0;
        store_data = '0; alu_result = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        check("rst_val", val, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // LW, zero wait, with a stray en in ACCESS that must be dropped.
        rbytes[0] = 8'h44; rbytes[1] = 8'h33; rbytes[2] = 8'h22; rbytes[3] = 8'h11;
        run_op("LW", OP_LOAD, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, 2);
        check("lw_ready_cycle", rdy_cycle, 32'd5);
        check("lw_bytes", n_bytes, 32'd4);
        check("lw_addr0", log_addr[0], 32'h0000_0100);
        check("lw_addr3", log_addr[3], 32'h0000_0103);
        check("lw_we", {31'd0, log_we[1]}, 32'd0);
        check("lw_val", val, 32'h1122_3344);
        check("lw_req_at_ready", {31'd0, req_at_ready}, 32'd0);
        check("lw_busy_at_ready", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        check("lw_no_extra_ready", {31'd0, ready}, 32'd0);
        check("lw_idle_busy", {31'd0, busy}, 32'd0);
        check("lw_val_held", val, 32'h1122_3344);

        // LB: upper bytes offered by memory must never be fetched.
        rbytes[0] = 8'h80; rbytes[1] = 8'hFF; rbytes[2] = 8'hFF; rbytes[3] = 8'hFF;
        run_op("LB", OP_LOAD, 3'b000, 32'h0000_0007, 32'h0, 32'h0, 0, 0);
        check("lb_ready_cycle", rdy_cycle, 32'd2);
        check("lb_req_cycles", req_cycles, 32'd1);
        check("lb_addr", log_addr[0], 32'h0000_0007);
        check("lb_val", val, 32'h0000_0080);

        // SH across the top of the address space with two wait states per byte.
        run_op("SH", OP_STORE, 3'b001, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0, 2, 0);
        check("sh_ready_cycle", rdy_cycle, 32'd7);
        check("sh_bytes", n_bytes, 32'd2);
        check("sh_addr0", log_addr[0], 32'hFFFF_FFFF);
        check("sh_wdata0", {24'd0, log_wdata[0]}, 32'h0000_00EF);
        check("sh_addr1", log_addr[1], 32'h0000_0000);
        check("sh_wdata1", {24'd0, log_wdata[1]}, 32'h0000_00BE);
        check("sh_we", {31'd0, log_we[0] & log_we[1]}, 32'd1);
        check("sh_val_cleared", val, 32'd0);

        // Reserved size 2'b11 behaves as a word store.
        run_op("SW11", OP_STORE, 3'b011, 32'h0000_0020, 32'h0102_0304, 32'h0, 0, 0);
        check("sw11_bytes", n_bytes, 32'd4);
        check("sw11_wdata3", {24'd0, log_wdata[3]}, 32'h0000_0001);
        check("sw11_addr3", log_addr[3], 32'h0000_0023);
        check("sw11_ready_cycle", rdy_cycle, 32'd5);

        // Non-memory op.
        run_op("ADDI", OP_ALU, 3'b000, 32'h0000_0400, 32'h0, 32'h0000_0005, 0, 0);
        check("addi_ready_cycle", rdy_cycle, 32'd1);
        check("addi_req_cycles", req_cycles, 32'd0);
        check("addi_val", val, 32'h0000_0005);

        // Reset mid-LW after the first byte.
        rbytes[0] = 8'h44; rbytes[1] = 8'h33; rbytes[2] = 8'h22; rbytes[3] = 8'h11;
        @(negedge clk);
        en = 1'b1; op = OP_LOAD; funct3 = 3'b010; addr = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0; op = OP_ALU;
        check("rlw_req_started", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h44;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rlw_req_async", {31'd0, bus.mem_req}, 32'd0);
        check("rlw_busy_async", {31'd0, busy}, 32'd0);
        check("rlw_val_async", val, 32'd0);
        check("rlw_ready_async", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn RST_LW reset after byte 0, val=0x%08h", val);
        rbytes[0] = 8'h5A;
        run_op("LB2", OP_LOAD, 3'b100, 32'h0000_0040, 32'h0, 32'h0, 0, 0);
        check("lb2_ready_cycle", rdy_cycle, 32'd2);
        check("lb2_val", val, 32'h0000_005A);

        // Spurious acks while idle.
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("spur_ready", {31'd0, ready}, 32'd0);
            check("spur_busy", {31'd0, busy}, 32'd0);
            check("spur_req", {31'd0, bus.mem_req}, 32'd0);
        end
        bus.mem_ack = 1'b0;
        check("spur_val", val, 32'h0000_005A);
        $display("txn SPURIOUS_ACK val=0x%08h", val);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
